sevenseg_scan_driver: RTL and testbench

//  Parametrised time-multiplexed driver for a bank of NUM_DIGITS common-bus seven-segment digits.

---
 rtl/sevenseg_scan_driver_pkg.sv | 31 +++
 rtl/sevenseg_scan_driver_if.sv | 23 ++
 rtl/seg7_glyph_decode.sv | 32 +++
 rtl/sevenseg_scan_driver.sv | 98 +++++++++
 tb/tb_sevenseg_scan_driver.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared glyph constants and segment bit order for the seven-segment scan driver.
// Segment vectors are packed {g,f,e,d,c,b,a}; a set bit lights the segment.
package sevenseg_scan_driver_pkg;

  localparam int unsigned BitA = 0;
  localparam int unsigned BitB = 1;
  localparam int unsigned BitC = 2;
  localparam int unsigned BitD = 3;
  localparam int unsigned BitE = 4;
  localparam int unsigned BitF = 5;
  localparam int unsigned BitG = 6;

  localparam logic [6:0] SegBlank = 7'b000_0000;
  localparam logic [6:0] Seg0     = 7'b011_1111;
  localparam logic [6:0] Seg1     = 7'b000_0110;
  localparam logic [6:0] Seg2     = 7'b101_1011;
  localparam logic [6:0] Seg3     = 7'b100_1111;
  localparam logic [6:0] Seg4     = 7'b110_0110;
  localparam logic [6:0] Seg5     = 7'b110_1101;
  localparam logic [6:0] Seg6     = 7'b111_1101;
  localparam logic [6:0] Seg7     = 7'b000_0111;
  localparam logic [6:0] Seg8     = 7'b111_1111;
  localparam logic [6:0] Seg9     = 7'b110_1111;
  localparam logic [6:0] SegA     = 7'b111_0111;
  localparam logic [6:0] SegB     = 7'b111_1100;
  localparam logic [6:0] SegC     = 7'b011_1001;
  localparam logic [6:0] SegD     = 7'b101_1110;
  localparam logic [6:0] SegE     = 7'b111_1001;
  localparam logic [6:0] SegF     = 7'b111_0001;

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Display bus between a datapath (master) and the scan driver (slave).
interface sevenseg_scan_driver_if #(
  parameter int unsigned NumDigits = 4
) ();

  logic [4*NumDigits-1:0] data_in;
  logic                   load;
  logic                   hex_mode;
  logic [6:0]             seg;
  logic [NumDigits-1:0]   dig_en;
  logic                   out_range;

  modport master (
    output data_in, load, hex_mode,
    input  seg, dig_en, out_range
  );

  modport slave (
    input  data_in, load, hex_mode,
    output seg, dig_en, out_range
  );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational nibble-to-glyph decoder; BCD mode blanks codes 10-15.
module seg7_glyph_decode
  import sevenseg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    unique case (nibble_i)
      4'h0: seg_o = Seg0;
      4'h1: seg_o = Seg1;
      4'h2: seg_o = Seg2;
      4'h3: seg_o = Seg3;
      4'h4: seg_o = Seg4;
      4'h5: seg_o = Seg5;
      4'h6: seg_o = Seg6;
      4'h7: seg_o = Seg7;
      4'h8: seg_o = Seg8;
      4'h9: seg_o = Seg9;
      4'hA: seg_o = hex_mode_i ? SegA : SegBlank;
      4'hB: seg_o = hex_mode_i ? SegB : SegBlank;
      4'hC: seg_o = hex_mode_i ? SegC : SegBlank;
      4'hD: seg_o = hex_mode_i ? SegD : SegBlank;
      4'hE: seg_o = hex_mode_i ? SegE : SegBlank;
      4'hF: seg_o = hex_mode_i ? SegF : SegBlank;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with registered outputs.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sevenseg_scan_driver_if.slave bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  logic [PreW-1:0]         presc_q, presc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    out_range_q, out_range_d;

  logic [3:0] nibble;
  logic [6:0] glyph;
  logic       any_gt9;
  logic       blank;

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PreLast) begin
      presc_d = '0;
      idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  assign shadow_d = bus.load ? bus.data_in : shadow_q;

  always_comb begin
    nibble  = 4'd0;
    any_gt9 = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) nibble = shadow_q[4*i +: 4];
      if (shadow_q[4*i +: 4] > 4'd9) any_gt9 = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; hz stays set while every nibble so far is zero.
  always_comb begin
    logic hz;
    hz    = 1'b1;
    blank = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      hz = hz & (shadow_q[4*i +: 4] == 4'd0);
      if (i != 0 && idx_q == IdxW'(i)) blank = hz;
    end
  end
`else
  assign blank = 1'b0;
`endif

  seg7_glyph_decode u_decode (
    .nibble_i   (nibble),
    .hex_mode_i (bus.hex_mode),
    .seg_o      (glyph)
  );

  assign seg_d       = blank ? SegBlank : glyph;
  assign dig_en_d    = NUM_DIGITS'(1) << idx_q;
  assign out_range_d = ~bus.hex_mode & any_gt9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      seg_q       <= '0;
      dig_en_q    <= '0;
      out_range_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      dig_en_q    <= dig_en_d;
      out_range_q <= out_range_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dig_en    = dig_en_q;
  assign bus.out_range = out_range_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: two scan drivers (REFRESH_DIV 4 and 1) share stimulus; a letter-based
// glyph model predicts each edge. Honours LEADING_ZERO_BLANK_EN like the design.
module tb_sevenseg_scan_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned RdA = 4;
  localparam int unsigned RdB = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.NumDigits(N)) bus_a ();
  sevenseg_scan_driver_if #(.NumDigits(N)) bus_b ();

  assign bus_b.data_in  = bus_a.data_in;
  assign bus_b.load     = bus_a.load;
  assign bus_b.hex_mode = bus_a.hex_mode;

  sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RdA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RdB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int unsigned tag;
    logic [6:0]  seg_a;
    logic [3:0]  dig_a;
    logic [6:0]  seg_b;
    logic [3:0]  dig_b;
    logic        rng;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_cnt = 0;
  int unsigned checks   = 0;
  int unsigned errors   = 0;

  // Model state: edges since reset release and the latched display value.
  int unsigned cyc      = 0;
  logic [15:0] m_shadow = 16'd0;
  logic [15:0] cur_d    = 16'd0;
  logic        cur_hex  = 1'b0;

  string glyph_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                            "aefg"};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [6:0] model_glyph(input logic [3:0] v, input logic hex);
    string      s;
    logic [6:0] r;
    r = 7'd0;
    if (!hex && v > 4'd9) return 7'd0;
    s = glyph_tbl[v];
    for (int k = 0; k < s.len(); k++) r[int'(s[k]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input logic [15:0] sh, input int unsigned idx,
                                           input logic hex);
    logic [3:0] v;
    v = 4'((sh >> (4 * idx)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 0 && (sh >> (4 * idx)) == 16'd0) return 7'd0;
`endif
    return model_glyph(v, hex);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the expectation for the coming edge.
  task automatic step(input logic rst, input logic ld, input logic [15:0] d, input logic hex);
    exp_t        e;
    int unsigned ia, ib;
    logic        gt9;
    @(negedge clk);
    #1;
    rst_n          = rst;
    bus_a.load     = ld;
    bus_a.data_in  = d;
    bus_a.hex_mode = hex;
    e.tag = edge_cnt;
    if (!rst) begin
      e.seg_a = 7'd0; e.dig_a = 4'd0; e.seg_b = 7'd0; e.dig_b = 4'd0; e.rng = 1'b0;
      cyc      = 0;
      m_shadow = 16'd0;
    end else begin
      ia  = (cyc / RdA) % N;
      ib  = (cyc / RdB) % N;
      gt9 = 1'b0;
      for (int i = 0; i < int'(N); i++)
        if (((m_shadow >> (4 * i)) & 16'hF) > 16'd9) gt9 = 1'b1;
      e.dig_a = 4'(1 << ia);
      e.dig_b = 4'(1 << ib);
      e.seg_a = model_seg(m_shadow, ia, hex);
      e.seg_b = model_seg(m_shadow, ib, hex);
      e.rng   = !hex && gt9;
      cyc++;
      if (ld) m_shadow = d;
    end
    sb.push_back(e);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(1'b1, 1'b0, cur_d, cur_hex);
  endtask

  task automatic load_val(input logic [15:0] d, input logic hex);
    cur_d   = d;
    cur_hex = hex;
    step(1'b1, 1'b1, d, hex);
  endtask

  // Monitor: compare every expectation whose edge has already occurred.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag < edge_cnt) begin
        e = sb.pop_front();
        chk("seg_a",       32'(bus_a.seg),       32'(e.seg_a));
        chk("dig_en_a",    32'(bus_a.dig_en),    32'(e.dig_a));
        chk("out_range_a", 32'(bus_a.out_range), 32'(e.rng));
        chk("seg_b",       32'(bus_b.seg),       32'(e.seg_b));
        chk("dig_en_b",    32'(bus_b.dig_en),    32'(e.dig_b));
        chk("out_range_b", 32'(bus_b.out_range), 32'(e.rng));
      end
    end
  end

  initial begin
    logic [15:0] d;
    bus_a.load     = 1'b0;
    bus_a.data_in  = 16'd0;
    bus_a.hex_mode = 1'b0;
    repeat (3) step(1'b0, 1'b0, 16'd0, 1'b0);
    run(20);

    load_val(16'h1234, 1'b0);
    run(20);
    load_val(16'h00AF, 1'b1);
    run(20);
    cur_hex = 1'b0;
    run(20);
    load_val(16'h0050, 1'b0);
    run(20);
    load_val(16'h0000, 1'b1);
    run(20);

    // Held load: shadow tracks data_in every cycle.
    for (int k = 0; k < 12; k++) begin
      cur_d = 16'($urandom);
      step(1'b1, 1'b1, cur_d, cur_hex);
    end
    run(8);

    // Async reset in the middle of digit 2's slot.
    load_val(16'h9876, 1'b0);
    while ((cyc % 16) != 10) run(1);
    step(1'b0, 1'b0, cur_d, cur_hex);
    #1;
    chk("async_seg",    32'(bus_a.seg),       32'd0);
    chk("async_dig_en", 32'(bus_a.dig_en),    32'd0);
    chk("async_range",  32'(bus_a.out_range), 32'd0);
    step(1'b0, 1'b0, cur_d, cur_hex);
    run(20);

    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 9) == 0) cur_hex = ~cur_hex;
      for (int i = 0; i < int'(N); i++)
        d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) begin
        step(1'b0, 1'b0, d, cur_hex);
      end else if ($urandom_range(0, 5) == 0) begin
        cur_d = d;
        step(1'b1, 1'b1, d, cur_hex);
      end else begin
        step(1'b1, 1'b0, d, cur_hex);
      end
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
